// File: rtl/nn_pkg.sv
// Shared definitions for the autoencoder datapath.
//   - Word/index widths and the Q-format fraction used by every layer.
//   - Layer sequencer FSM state encoding.
//   - Base addresses of each layer block inside the weight ram.
//     A block holds d_out biases followed by d_out*d_in weights, row-major.
package nn_pkg;

    localparam int ADDR_W = 33;
    localparam int DATA_W = 16;
    localparam int DIM_W  = 10;
    localparam int FRAC   = 8;
    localparam int ACC_W  = 40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_e;

    // Network shape 784-400-200-2-200-400-784.
    // w1 is placed where the weight image puts it; the later blocks follow
    // back to back using the bias+weight block size.
    localparam logic [ADDR_W-1:0] W0_BASE = 33'd0;       // 784 -> 400
    localparam logic [ADDR_W-1:0] W1_BASE = 33'd314384;  // 400 -> 200
    localparam logic [ADDR_W-1:0] W2_BASE = 33'd394584;  // 200 -> 2
    localparam logic [ADDR_W-1:0] W3_BASE = 33'd394986;  // 2   -> 200
    localparam logic [ADDR_W-1:0] W4_BASE = 33'd395586;  // 200 -> 400
    localparam logic [ADDR_W-1:0] W5_BASE = 33'd475986;  // 400 -> 784

    // Number of ram words occupied by one layer block.
    function automatic logic [ADDR_W-1:0] layer_words(input logic [DIM_W-1:0] din,
                                                     input logic [DIM_W-1:0] dout);
        return ADDR_W'(dout) + ADDR_W'(din) * ADDR_W'(dout);
    endfunction

endpackage

// File: rtl/fx_requant.sv
// Requantise a Q(ACC_W-FRAC).FRAC accumulator back to a DATA_W activation.
//   acc_i      : signed accumulator
//   relu_en_i  : clamp negative results to zero
//   res_o      : (acc_i >>> FRAC) saturated to the signed DATA_W range
// Purely combinational.
module fx_requant
    import nn_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic                     relu_en_i,
    output logic        [DATA_W-1:0] res_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v, input logic en);
        return (en && v[DATA_W-1]) ? '0 : v;
    endfunction

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_i >>> FRAC;
    assign res_o   = relu(saturate(shifted), relu_en_i);

endmodule

// File: rtl/dense_layer_sequencer.sv
// Sequences one fully-connected layer: reads biases/weights from the weight
// ram, activations from the layer input buffer, multiply-accumulates in fixed
// point and streams one requantised result per output neuron.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a layer (only sampled while idle)
//   base_addr/d_in/d_out/relu_en  layer description, latched on start
//   busy, done          layer in progress / one-cycle completion pulse
//   ram_index/ram_write/ram_data  weight ram port (read only, 1-cycle latency)
//   act_addr/act_data   input buffer port (1-cycle latency)
//   out_valid/out_ready/out_idx/out_data  result stream
module dense_layer_sequencer
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  d_in,
    input  logic [DIM_W-1:0]  d_out,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_index,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DIM_W-1:0]  act_addr,
    input  logic [DATA_W-1:0] act_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] wnext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] bias_addr_d;
    logic [DIM_W-1:0]  din_q, dout_q;
    logic [DIM_W-1:0]  j_q, k_q, k_d;
    logic [DIM_W-1:0]  act_addr_q, out_idx_q;
    logic [DATA_W-1:0] out_data_q, req_res;
    logic              relu_q, done_q;
    logic              empty_layer, mac_last, neuron_last;

    logic signed [2*DATA_W-1:0] w_ext, a_ext, prod;
    logic signed [ACC_W-1:0]    acc_q, acc_sum, bias_ext, prod_ext;

    assign empty_layer = (d_in == '0) || (d_out == '0);
    assign mac_last    = (k_q == din_q - DIM_W'(1));
    assign neuron_last = (j_q == dout_q - DIM_W'(1));

    // ram_data/act_data always refer to the addresses driven one cycle earlier
    assign w_ext    = {{DATA_W{ram_data[DATA_W-1]}}, ram_data};
    assign a_ext    = {{DATA_W{act_data[DATA_W-1]}}, act_data};
    assign prod     = w_ext * a_ext;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){ram_data[DATA_W-1]}}, ram_data};
    assign acc_sum  = acc_q + prod_ext;

    fx_requant u_requant (
        .acc_i     (acc_sum),
        .relu_en_i (relu_q),
        .res_o     (req_res)
    );

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = empty_layer ? S_DONE : S_BIAS;
            S_BIAS:  state_d = S_MAC;
            S_MAC:   if (mac_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_EMIT;
            S_EMIT:  if (out_ready) state_d = neuron_last ? S_DONE : S_BIAS;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---- outputs ----
    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_EMIT);
        done      = done_q;
        ram_write = 1'b0;
        ram_index = addr_q;
        act_addr  = act_addr_q;
        out_idx   = out_idx_q;
        out_data  = out_data_q;
    end

    // Entering BIAS from IDLE uses the live base_addr because base_q is being
    // loaded on the same edge.
    always_comb begin
        bias_addr_d = base_q + ADDR_W'(j_q) + ADDR_W'(1);
        if (state_q == S_IDLE) begin
            bias_addr_d = base_addr;
        end
        k_d = (state_q == S_MAC) ? k_q + DIM_W'(1) : '0;
    end

    // ---- address generation, accumulate, result capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            din_q      <= '0;
            dout_q     <= '0;
            relu_q     <= 1'b0;
            j_q        <= '0;
            k_q        <= '0;
            wnext_q    <= '0;
            addr_q     <= '0;
            act_addr_q <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);

            if (state_q == S_IDLE && start) begin
                base_q  <= base_addr;
                din_q   <= d_in;
                dout_q  <= d_out;
                relu_q  <= relu_en;
                j_q     <= '0;
                // weights of consecutive neurons are contiguous, so one
                // running pointer covers the whole layer
                wnext_q <= base_addr + ADDR_W'(d_out);
            end

            if (state_q == S_EMIT && out_ready && !neuron_last) begin
                j_q <= j_q + DIM_W'(1);
            end

            if (state_d == S_BIAS) begin
                addr_q <= bias_addr_d;
            end else if (state_d == S_MAC) begin
                addr_q     <= wnext_q;
                wnext_q    <= wnext_q + ADDR_W'(1);
                act_addr_q <= k_d;
                k_q        <= k_d;
            end

            // first MAC cycle sees the bias word; later ones see a product
            if (state_q == S_MAC) begin
                acc_q <= (k_q == '0) ? (bias_ext <<< FRAC) : acc_sum;
            end else if (state_q == S_DRAIN) begin
                acc_q      <= acc_sum;
                out_data_q <= req_res;
                out_idx_q  <= j_q;
            end
        end
    end

endmodule
